// File: rtl/ld_project_pkg.sv
// Shared codes and types for the two-home appliance settings controller.
// Optional feature macro: AC_TIMER_COUNTDOWN_EN (AC timer counts down per clock).
package ld_project_pkg;

    localparam int VAL_W = 5;

    typedef enum logic [1:0] {
        DEV_FRIDGE = 2'b00,
        DEV_AC     = 2'b01,
        DEV_WASHER = 2'b10,
        DEV_NONE   = 2'b11
    } dev_e;

    typedef enum logic [1:0] {
        AC_TEMP  = 2'b00,
        AC_CAP   = 2'b01,
        AC_FAN   = 2'b10,
        AC_TIMER = 2'b11
    } ac_func_e;

    typedef enum logic [1:0] {
        FR_TEMP = 2'b00,
        FR_CAP  = 2'b01,
        FR_ICE  = 2'b10,
        FR_NONE = 2'b11
    } fr_func_e;

    // Every setting of one home, as held by one ld_appliance_unit.
    typedef struct packed {
        logic [VAL_W-1:0] fgt;
        logic [VAL_W-1:0] frt;
        logic [VAL_W-1:0] fgc;
        logic [VAL_W-1:0] frc;
        logic             ice;
        logic [VAL_W-1:0] actemp;
        logic [VAL_W-1:0] accap;
        logic [VAL_W-1:0] acfan;
        logic [VAL_W-1:0] actimer;
        logic [VAL_W-1:0] wash;
        logic [VAL_W-1:0] rinse;
        logic [VAL_W-1:0] spin;
        logic [VAL_W-1:0] cloth;
    } unit_regs_t;

    // Washer sub-command decode: s3=0 loads, s3=1 with s5=1 clears, else holds.
    function automatic logic washer_load(input logic s3);
        return ~s3;
    endfunction

    function automatic logic washer_clear(input logic s3, input logic s5);
        return s3 & s5;
    endfunction

endpackage

// File: rtl/ld_project_if.sv
// Select/value bus and settings outputs of the appliance controller.
// master drives selects and values; slave (the controller) drives the settings.
interface ld_project_if;
    import ld_project_pkg::*;

    logic             s0, s1, s2, s3, s4, s5;
    logic [VAL_W-1:0] inp;
    logic [VAL_W-1:0] wash, rinse, spin, cloth;

    logic [VAL_W-1:0] fgt1, fgt2, frt1, frt2;
    logic [VAL_W-1:0] fgc1, fgc2, frc1, frc2;
    logic             ice1, ice2;
    logic [VAL_W-1:0] actemp1, actemp2, accap1, accap2;
    logic [VAL_W-1:0] acfan1, acfan2, actimer1, actimer2;
    logic [VAL_W-1:0] wash_out_1, wash_out_2, rinse_out_1, rinse_out_2;
    logic [VAL_W-1:0] spin_out_1, spin_out_2, cloth_out_1, cloth_out_2;

    modport master (
        output s0, s1, s2, s3, s4, s5, inp, wash, rinse, spin, cloth,
        input  fgt1, fgt2, frt1, frt2, fgc1, fgc2, frc1, frc2, ice1, ice2,
        input  actemp1, actemp2, accap1, accap2, acfan1, acfan2, actimer1, actimer2,
        input  wash_out_1, wash_out_2, rinse_out_1, rinse_out_2,
        input  spin_out_1, spin_out_2, cloth_out_1, cloth_out_2
    );

    modport slave (
        input  s0, s1, s2, s3, s4, s5, inp, wash, rinse, spin, cloth,
        output fgt1, fgt2, frt1, frt2, fgc1, fgc2, frc1, frc2, ice1, ice2,
        output actemp1, actemp2, accap1, accap2, acfan1, acfan2, actimer1, actimer2,
        output wash_out_1, wash_out_2, rinse_out_1, rinse_out_2,
        output spin_out_1, spin_out_2, cloth_out_1, cloth_out_2
    );

endinterface

// File: rtl/ld_appliance_unit.sv
// One home's fridge, AC and washer setting registers, written only when en is high.
// With AC_TIMER_COUNTDOWN_EN the AC timer counts down and clears the fan on expiry.
module ld_appliance_unit
    import ld_project_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       dev,
    input  logic [1:0]       func,
    input  logic             sub,
    input  logic [VAL_W-1:0] inp,
    input  logic [VAL_W-1:0] wash,
    input  logic [VAL_W-1:0] rinse,
    input  logic [VAL_W-1:0] spin,
    input  logic [VAL_W-1:0] cloth,
    output unit_regs_t       regs
);

    logic fr_sel, ac_sel, wm_sel;

    // Selects carrying X/Z never compare equal, so unaddressed banks hold.
    always_comb begin
        fr_sel = 1'b0;
        ac_sel = 1'b0;
        wm_sel = 1'b0;
        if (en == 1'b1) begin
            fr_sel = (dev == DEV_FRIDGE);
            ac_sel = (dev == DEV_AC);
            wm_sel = (dev == DEV_WASHER);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '0;
        end else begin
`ifdef AC_TIMER_COUNTDOWN_EN
            // Countdown first; an explicit write below in the same edge overrides it.
            if (regs.actimer != '0) begin
                regs.actimer <= regs.actimer - VAL_W'(1);
            end
            if (regs.actimer == VAL_W'(1)) begin
                regs.acfan <= '0;
            end
`endif
            if (fr_sel == 1'b1) begin
                case (func)
                    FR_TEMP: begin
                        if (sub) regs.frt <= inp;
                        else     regs.fgt <= inp;
                    end
                    FR_CAP: begin
                        if (sub) regs.frc <= inp;
                        else     regs.fgc <= inp;
                    end
                    FR_ICE:  regs.ice <= inp[0];
                    default: ;
                endcase
            end

            if (ac_sel == 1'b1) begin
                case (func)
                    AC_TEMP:  regs.actemp  <= inp;
                    AC_CAP:   regs.accap   <= inp;
                    AC_FAN:   regs.acfan   <= inp;
                    AC_TIMER: regs.actimer <= inp;
                    default:  ;
                endcase
            end

            if (wm_sel == 1'b1) begin
                if (washer_load(func[1]) == 1'b1) begin
                    regs.wash  <= wash;
                    regs.rinse <= rinse;
                    regs.spin  <= spin;
                    regs.cloth <= cloth;
                end else if (washer_clear(func[1], sub) == 1'b1) begin
                    regs.wash  <= '0;
                    regs.rinse <= '0;
                    regs.spin  <= '0;
                    regs.cloth <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/ld_project.sv
// Two-home appliance settings controller top: s2 steers each write to one unit.
// Optional feature macro: AC_TIMER_COUNTDOWN_EN (handled inside ld_appliance_unit).
module ld_project
    import ld_project_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    ld_project_if.slave  bus
);

    logic [1:0] dev;
    logic [1:0] func;
    logic       en1, en2;
    unit_regs_t u1, u2;

    assign dev  = {bus.s0, bus.s1};
    assign func = {bus.s3, bus.s4};
    assign en1  = (bus.s2 == 1'b0);
    assign en2  = (bus.s2 == 1'b1);

    ld_appliance_unit u_unit1 (
        .clk   (clk),
        .rst   (rst),
        .en    (en1),
        .dev   (dev),
        .func  (func),
        .sub   (bus.s5),
        .inp   (bus.inp),
        .wash  (bus.wash),
        .rinse (bus.rinse),
        .spin  (bus.spin),
        .cloth (bus.cloth),
        .regs  (u1)
    );

    ld_appliance_unit u_unit2 (
        .clk   (clk),
        .rst   (rst),
        .en    (en2),
        .dev   (dev),
        .func  (func),
        .sub   (bus.s5),
        .inp   (bus.inp),
        .wash  (bus.wash),
        .rinse (bus.rinse),
        .spin  (bus.spin),
        .cloth (bus.cloth),
        .regs  (u2)
    );

    assign bus.fgt1        = u1.fgt;
    assign bus.frt1        = u1.frt;
    assign bus.fgc1        = u1.fgc;
    assign bus.frc1        = u1.frc;
    assign bus.ice1        = u1.ice;
    assign bus.actemp1     = u1.actemp;
    assign bus.accap1      = u1.accap;
    assign bus.acfan1      = u1.acfan;
    assign bus.actimer1    = u1.actimer;
    assign bus.wash_out_1  = u1.wash;
    assign bus.rinse_out_1 = u1.rinse;
    assign bus.spin_out_1  = u1.spin;
    assign bus.cloth_out_1 = u1.cloth;

    assign bus.fgt2        = u2.fgt;
    assign bus.frt2        = u2.frt;
    assign bus.fgc2        = u2.fgc;
    assign bus.frc2        = u2.frc;
    assign bus.ice2        = u2.ice;
    assign bus.actemp2     = u2.actemp;
    assign bus.accap2      = u2.accap;
    assign bus.acfan2      = u2.acfan;
    assign bus.actimer2    = u2.actimer;
    assign bus.wash_out_2  = u2.wash;
    assign bus.rinse_out_2 = u2.rinse;
    assign bus.spin_out_2  = u2.spin;
    assign bus.cloth_out_2 = u2.cloth;

endmodule

// File: tb/tb_ld_project.sv
// Bench for ld_project: directed scenarios plus random writes against a table model.
// Honours AC_TIMER_COUNTDOWN_EN the same way the design does.
module tb_ld_project;
    import ld_project_pkg::*;

    localparam int NF    = 13;
    localparam int F_FGT = 0;
    localparam int F_FRT = 1;
    localparam int F_FGC = 2;
    localparam int F_FRC = 3;
    localparam int F_ICE = 4;
    localparam int F_ACT = 5;
    localparam int F_ACF = 7;
    localparam int F_TIM = 8;
    localparam int F_WSH = 9;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [4:0] m [2][NF];

    ld_project_if bus ();
    ld_project dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [129:0] snap();
        return {bus.fgt1, bus.frt1, bus.fgc1, bus.frc1, 4'b0, bus.ice1,
                bus.actemp1, bus.accap1, bus.acfan1, bus.actimer1,
                bus.wash_out_1, bus.rinse_out_1, bus.spin_out_1, bus.cloth_out_1,
                bus.fgt2, bus.frt2, bus.fgc2, bus.frc2, 4'b0, bus.ice2,
                bus.actemp2, bus.accap2, bus.acfan2, bus.actimer2,
                bus.wash_out_2, bus.rinse_out_2, bus.spin_out_2, bus.cloth_out_2};
    endfunction

    function automatic logic [129:0] expect_vec();
        logic [129:0] e = '0;
        for (int u = 0; u < 2; u++)
            for (int k = 0; k < NF; k++)
                e = {e[124:0], m[u][k]};
        return e;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++)
            for (int k = 0; k < NF; k++)
                m[u][k] = '0;
    endtask

    // Settings table update for one rising edge.
    task automatic model_edge(input logic [1:0] dev, input logic unit, input logic [1:0] fn,
                              input logic sub, input logic [4:0] v, input logic [4:0] w,
                              input logic [4:0] r, input logic [4:0] sp, input logic [4:0] c);
`ifdef AC_TIMER_COUNTDOWN_EN
        for (int u = 0; u < 2; u++) begin
            if (m[u][F_TIM] != 0) begin
                if (m[u][F_TIM] == 1) m[u][F_ACF] = 0;
                m[u][F_TIM] = m[u][F_TIM] - 1;
            end
        end
`endif
        case (dev)
            2'd0: begin
                if (fn == 0)      m[unit][sub ? F_FRT : F_FGT] = v;
                else if (fn == 1) m[unit][sub ? F_FRC : F_FGC] = v;
                else if (fn == 2) m[unit][F_ICE] = {4'b0, v[0]};
            end
            2'd1: m[unit][F_ACT + int'(fn)] = v;
            2'd2: begin
                if (fn < 2) begin
                    m[unit][F_WSH] = w; m[unit][F_WSH+1] = r;
                    m[unit][F_WSH+2] = sp; m[unit][F_WSH+3] = c;
                end else if (sub) begin
                    for (int k = 0; k < 4; k++) m[unit][F_WSH+k] = 0;
                end
            end
            default: ;
        endcase
    endtask

    task automatic drive(input logic [1:0] dev, input logic unit, input logic [1:0] fn,
                         input logic sub, input logic [4:0] v, input logic [4:0] w,
                         input logic [4:0] r, input logic [4:0] sp, input logic [4:0] c);
        bus.s0 = dev[1]; bus.s1 = dev[0]; bus.s2 = unit;
        bus.s3 = fn[1];  bus.s4 = fn[0];  bus.s5 = sub;
        bus.inp = v; bus.wash = w; bus.rinse = r; bus.spin = sp; bus.cloth = c;
    endtask

    task automatic step(input logic [1:0] dev, input logic unit, input logic [1:0] fn,
                        input logic sub, input logic [4:0] v, input logic [4:0] w = 0,
                        input logic [4:0] r = 0, input logic [4:0] sp = 0,
                        input logic [4:0] c = 0);
        @(negedge clk);
        drive(dev, unit, fn, sub, v, w, r, sp, c);
        @(posedge clk);
        model_edge(dev, unit, fn, sub, v, w, r, sp, c);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(2'd3, 1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (snap() !== expect_vec()) begin
            bad++; $display("FAIL reset_state got=%h exp=%h", snap(), expect_vec());
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fridge();
        step(2'd0, 1'b0, 2'd0, 1'b0, 5'b10101);
        total++;
        if (bus.fgt1 !== 5'd21 || snap() !== expect_vec()) begin
            bad++; $display("FAIL fridge_fgt1 got=%h exp=%h", snap(), expect_vec());
        end
        step(2'd0, 1'b0, 2'd0, 1'b1, 5'b10101);
        total++;
        if (bus.frt1 !== 5'd21 || snap() !== expect_vec()) begin
            bad++; $display("FAIL fridge_frt1 got=%h exp=%h", snap(), expect_vec());
        end
        step(2'd0, 1'b1, 2'd1, 1'b1, 5'd13);
        total++;
        if (bus.frc2 !== 5'd13 || snap() !== expect_vec()) begin
            bad++; $display("FAIL fridge_frc2 got=%h exp=%h", snap(), expect_vec());
        end
        step(2'd0, 1'b1, 2'd3, 1'b0, 5'd31);
        total++;
        if (snap() !== expect_vec()) begin
            bad++; $display("FAIL fridge_nowrite got=%h exp=%h", snap(), expect_vec());
        end
    endtask

    task automatic test_ice();
        step(2'd0, 1'b1, 2'd2, 1'b1, 5'b00001);
        total++;
        if (bus.ice2 !== 1'b1 || bus.ice1 !== 1'b0 || snap() !== expect_vec()) begin
            bad++; $display("FAIL ice2_set got=%h exp=%h", snap(), expect_vec());
        end
        step(2'd0, 1'b1, 2'd2, 1'b0, 5'b00000);
        total++;
        if (bus.ice2 !== 1'b0 || snap() !== expect_vec()) begin
            bad++; $display("FAIL ice2_clr got=%h exp=%h", snap(), expect_vec());
        end
    endtask

    task automatic test_ac();
        step(2'd1, 1'b1, 2'd2, 1'b0, 5'b01010);
        total++;
        if (bus.acfan2 !== 5'd10 || snap() !== expect_vec()) begin
            bad++; $display("FAIL ac_fan2 got=%h exp=%h", snap(), expect_vec());
        end
        step(2'd1, 1'b0, 2'd1, 1'b1, 5'b00100);
        total++;
        if (bus.accap1 !== 5'd4 || bus.acfan2 !== 5'd10 || snap() !== expect_vec()) begin
            bad++; $display("FAIL ac_cap1 got=%h exp=%h", snap(), expect_vec());
        end
        step(2'd1, 1'b0, 2'd0, 1'b0, 5'd17);
        total++;
        if (bus.actemp1 !== 5'd17 || snap() !== expect_vec()) begin
            bad++; $display("FAIL ac_temp1 got=%h exp=%h", snap(), expect_vec());
        end
    endtask

    task automatic test_washer();
        step(2'd2, 1'b0, 2'd1, 1'b0, 5'd0, 5'd31, 5'd31, 5'd31, 5'd31);
        total++;
        if ({bus.wash_out_1, bus.rinse_out_1, bus.spin_out_1, bus.cloth_out_1} !== {4{5'd31}} ||
            {bus.wash_out_2, bus.rinse_out_2, bus.spin_out_2, bus.cloth_out_2} !== 20'd0) begin
            bad++; $display("FAIL washer_load got=%h exp=%h", snap(), expect_vec());
        end
        step(2'd2, 1'b0, 2'd2, 1'b0, 5'd0, 5'd3, 5'd4, 5'd5, 5'd6);
        total++;
        if ({bus.wash_out_1, bus.rinse_out_1, bus.spin_out_1, bus.cloth_out_1} !== {4{5'd31}} ||
            snap() !== expect_vec()) begin
            bad++; $display("FAIL washer_hold got=%h exp=%h", snap(), expect_vec());
        end
        step(2'd2, 1'b0, 2'd3, 1'b1, 5'd0, 5'd3, 5'd4, 5'd5, 5'd6);
        total++;
        if ({bus.wash_out_1, bus.rinse_out_1, bus.spin_out_1, bus.cloth_out_1} !== 20'd0 ||
            snap() !== expect_vec()) begin
            bad++; $display("FAIL washer_clear got=%h exp=%h", snap(), expect_vec());
        end
    endtask

    task automatic test_timer();
        logic [4:0] exp_tim [3];
        logic [4:0] exp_fan [3];
`ifdef AC_TIMER_COUNTDOWN_EN
        exp_tim = '{5'd2, 5'd1, 5'd0};
        exp_fan = '{5'd7, 5'd7, 5'd0};
`else
        exp_tim = '{5'd3, 5'd3, 5'd3};
        exp_fan = '{5'd7, 5'd7, 5'd7};
`endif
        step(2'd1, 1'b0, 2'd2, 1'b0, 5'd7);
        step(2'd1, 1'b0, 2'd3, 1'b0, 5'd3);
        total++;
        if (bus.actimer1 !== 5'd3 || snap() !== expect_vec()) begin
            bad++; $display("FAIL timer_load got=%0d exp=3", bus.actimer1);
        end
        for (int i = 0; i < 3; i++) begin
            step(2'd3, 1'b0, 2'd0, 1'b0, 5'd0);
            total++;
            if (bus.actimer1 !== exp_tim[i] || bus.acfan1 !== exp_fan[i] ||
                snap() !== expect_vec()) begin
                bad++;
                $display("FAIL timer_tick%0d got tim=%0d fan=%0d exp tim=%0d fan=%0d",
                         i, bus.actimer1, bus.acfan1, exp_tim[i], exp_fan[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            total++;
            if (snap() !== expect_vec()) begin
                bad++; $display("FAIL random_%0d got=%h exp=%h", i, snap(), expect_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive(2'd0, 1'b0, 2'd0, 1'b0, 5'd9, 5'd0, 5'd0, 5'd0, 5'd0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        total++;
        if (snap() !== expect_vec()) begin
            bad++; $display("FAIL reset_async got=%h exp=%h", snap(), expect_vec());
        end
        @(posedge clk);
        #1;
        total++;
        if (snap() !== expect_vec()) begin
            bad++; $display("FAIL reset_held got=%h exp=%h", snap(), expect_vec());
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        model_edge(2'd0, 1'b0, 2'd0, 1'b0, 5'd9, 5'd0, 5'd0, 5'd0, 5'd0);
        #1;
        total++;
        if (bus.fgt1 !== 5'd9 || snap() !== expect_vec()) begin
            bad++; $display("FAIL reset_first_write got=%h exp=%h", snap(), expect_vec());
        end
    endtask

    initial begin
        test_reset();
        test_fridge();
        test_ice();
        test_ac();
        test_washer();
        test_timer();
        test_random();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ld_project.md
# ld_project

Two-home appliance settings controller: one shared 5-bit value bus and a set of selector bits program register banks for two refrigerators, two air conditioners and two washing machines. Every setting is held in a register and driven continuously on a dedicated output. It is the top-level control block; display and actuator logic consume its outputs.

## Interface
- No parameters; all value widths are fixed at 5 bits.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- s0, s1  input  1 each  device select {s0,s1}: 00 fridge, 01 AC, 10 washer, 11 none.
- s2  input  1  unit select: 0 → unit 1, 1 → unit 2.
- s3, s4  input  1 each  function select within the device.
- s5  input  1  fridge: 0 fridge compartment, 1 freezer. Washer: sub-command.
- inp  input  5  value bus for fridge and AC writes.
- wash, rinse, spin, cloth  input  5 each  washer program values.
- fgt1/fgt2, frt1/frt2  output  5  fridge / freezer temperature, units 1/2.
- fgc1/fgc2, frc1/frc2  output  5  fridge / freezer capacity, units 1/2.
- ice1, ice2  output  1  icemaker enable, units 1/2.
- actemp1/2, accap1/2, acfan1/2, actimer1/2  output  5  AC temperature, capacity, fan, timer.
- wash_out_1/2, rinse_out_1/2, spin_out_1/2, cloth_out_1/2  output  5  washer settings.

## Operation
- Every output is a register. rst forces all outputs to 0.
- Each rising edge performs at most one write, to the register addressed by {s0,s1}, s2, {s3,s4} and s5. All other registers hold.
- Fridge ({s0,s1}=00):
  - {s3,s4}=00: temperature ← inp; s5=0 → fgtN, s5=1 → frtN.
  - 01: capacity ← inp; s5=0 → fgcN, s5=1 → frcN.
  - 10: iceN ← inp[0]; s5 is ignored.
  - 11: no write.
- AC ({s0,s1}=01), s5 ignored:
  - {s3,s4}=00 → actempN; 01 → accapN; 10 → acfanN; 11 → actimerN. Each is loaded from inp.
- Washer ({s0,s1}=10), s4 ignored:
  - s3=0: load wash/rinse/spin/cloth into wash_out_N/rinse_out_N/spin_out_N/cloth_out_N in the same edge.
  - s3=1, s5=0: hold all four.
  - s3=1, s5=1: clear all four to 0.
- {s0,s1}=11: no write.
- Values are stored verbatim, with no clamping or range check.
- X or Z on a select bit must not corrupt registers that are not addressed. The bench only checks addressed behaviour with defined selects.

## Timing
- Write latency is one cycle: the new value is visible on the output right after the capturing rising edge.
- Selects and data are sampled together at that edge.
- Reset is asynchronous: outputs go to 0 immediately on rst assertion, including in the middle of a write. The first write takes effect at the first rising edge after rst deasserts.
- Unit 1 and unit 2 are never written in the same cycle.

## Configuration
- AC_TIMER_COUNTDOWN_EN defined:
  - Each nonzero actimerN decrements by 1 per clock, except in a cycle where actimerN is being written; the write wins.
  - On the edge where actimerN goes 1→0, acfanN is cleared to 0 in the same edge.
  - An actimerN of 0 stays at 0.
- Not defined: actimerN is a plain holding register.

## Structure
- Package ld_project_pkg holds:
  - Device codes: DEV_FRIDGE=2'b00, DEV_AC=2'b01, DEV_WASHER=2'b10.
  - AC function codes: AC_TEMP, AC_CAP, AC_FAN, AC_TIMER.
  - Fridge function codes: FR_TEMP, FR_CAP, FR_ICE.
  - Value width constant VAL_W=5.
- Sub-module ld_appliance_unit: one home's fridge, AC and washer registers plus a unit-enable input. It is instantiated twice, with s2 driving the enables.

## Test plan
- Assert rst mid-run → all 5-bit outputs 0 and ice1=ice2=0 immediately, before any clock edge.
- {s0,s1}=00, s2=0, {s3,s4}=00, s5=0, inp=10101 → fgt1=21 after the edge; frt1, fgt2 and all other outputs unchanged. Repeat with s5=1 → frt1=21.
- {s0,s1}=00, s2=1, {s3,s4}=10, inp=00001 → ice2=1, ice1 unchanged. Repeat with inp=0 → ice2=0.
- {s0,s1}=01, s2=1, {s3,s4}=10, inp=01010 → acfan2=10. Then s2=0, {s3,s4}=01, inp=00100 → accap1=4, acfan2 still 10.
- {s0,s1}=10, s2=0, s3=0, wash=rinse=spin=cloth=31 → all four unit-1 washer outputs 31, unit 2 at 0. Then s3=1, s5=0 → hold at 31. Then s3=1, s5=1 → all four 0.
- With the macro defined: AC write actimer1=3 → actimer1 reads 3,2,1,0 on successive edges, and acfan1 clears on the 1→0 edge. Without the macro: actimer1 stays 3.
